alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [31:0]          alu_srca,
    output logic [31:0]          alu_srcb,
    output logic [3:0]           alu_ctrl,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 alu_ltu,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic [2:0]           rsp_flags,
    output logic                 rsp_err
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] rot;
    logic            gnt_any, grant, can_accept, illegal;
    logic [IDW-1:0]  gnt_idx, sel;
    logic [2:0]      flags_m;

    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic [2:0]      rsp_flags_q, rsp_flags_d;
    logic            rsp_err_q, rsp_err_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    assign ptr      = rr_ptr_q;
    assign rr_ptr_d = grant ? IDW'((int'(gnt_idx) + 1) % NREQ) : rr_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Rotate so bit 0 is the requester at the search start.
    assign rot = NREQ'({req_valid, req_valid} >> ptr);

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && rot[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign can_accept = (state_q == EMPTY) | rsp_ready;
    assign grant      = can_accept & gnt_any;
    assign sel        = grant ? gnt_idx : ptr;

    always_comb begin
        req_ready = '0;
        alu_srca  = '0;
        alu_srcb  = '0;
        alu_ctrl  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant && gnt_idx == IDW'(i)) req_ready[i] = 1'b1;
            if (sel == IDW'(i)) begin
                alu_srca = req_a[32*i +: 32];
                alu_srcb = req_b[32*i +: 32];
                alu_ctrl = req_op[4*i +: 4];
            end
        end
    end

    assign illegal = alu_ctrl >= 4'b1010;
    assign flags_m = {(alu_ctrl == 4'b0110) & alu_ltu,
                      (alu_ctrl == 4'b0101) & alu_lt,
                      (alu_ctrl == 4'b0001) & alu_zero};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (rsp_ready && !grant) state_d = EMPTY;
        endcase
    end

    always_comb begin
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        if (grant) begin
            rsp_id_d     = gnt_idx;
            rsp_result_d = illegal ? 32'd0 : alu_result;
            rsp_flags_d  = illegal ? 3'd0 : flags_m;
            rsp_err_d    = illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed steps plus random traffic
// against a transaction-level model with a behavioural ALU.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [7:0]  req_op;
    logic [63:0] req_a, req_b;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, alu_lt, alu_ltu;
    logic        rsp_valid, rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic        rsp_err;

    int compared   = 0;
    int mismatched = 0;

    bit          m_full;
    int          m_rr;
    logic [0:0]  m_id;
    logic [31:0] m_res;
    logic [2:0]  m_flags;
    logic        m_err;
    int          last_g;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(2), .IDW(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = {31'd0, $signed(a) < $signed(b)};
            4'd6: r = {31'd0, a < b};
            4'd7: r = a << b[4:0];
            4'd8: r = a >> b[4:0];
            4'd9: r = $signed(a) >>> b[4:0];
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    // Flags not tied to the current op are driven X to exercise masking.
    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_srca, alu_srcb);
        alu_zero   = (alu_result == 32'd0);
        alu_lt     = (alu_ctrl == 4'd5) ? ($signed(alu_srca) < $signed(alu_srcb)) : 1'bx;
        alu_ltu    = (alu_ctrl == 4'd6) ? (alu_srca < alu_srcb) : 1'bx;
    end

    function automatic logic [35:0] exp_rsp(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic z, l, lu;
        if (op >= 4'd10) return {1'b1, 3'b000, 32'd0};
        z  = (op == 4'd1) && (a == b);
        l  = (op == 4'd5) && ($signed(a) < $signed(b));
        lu = (op == 4'd6) && (a < b);
        return {1'b0, lu, l, z, alu_fn(op, a, b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]      = v;
        req_op[4*i +: 4]  = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_rr   = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_cycle();
        int g, idx, p;
        logic [1:0] er;
        @(negedge clk);
        g = -1;
        if (!m_full || rsp_ready) begin
            for (int k = 0; k < 2; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_rr + k) % 2;
`endif
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        er = (g >= 0) ? 2'(1 << g) : 2'b00;
        chk("req_ready", req_ready, er);
`ifdef ALU_ARB_FIXED_PRIO_EN
        p = 0;
`else
        p = m_rr;
`endif
        if (g >= 0) begin
            chk("alu_ctrl", alu_ctrl, req_op[4*g +: 4]);
            chk("alu_srca", alu_srca, req_a[32*g +: 32]);
            chk("alu_srcb", alu_srcb, req_b[32*g +: 32]);
        end else begin
            chk("alu_ctrl_idle", alu_ctrl, req_op[4*p +: 4]);
        end
        last_g = g;
        if (g >= 0)
            {m_err, m_flags, m_res} = exp_rsp(req_op[4*g +: 4], req_a[32*g +: 32], req_b[32*g +: 32]);
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_full = 1'b1;
            m_id   = 1'(g);
            m_rr   = (g + 1) % 2;
        end else if (rsp_ready) begin
            m_full = 1'b0;
        end
        chk("rsp_valid", rsp_valid, m_full);
        if (m_full) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_flags", rsp_flags, m_flags);
            chk("rsp_err", rsp_err, m_err);
        end
    endtask

    initial begin
        int exp_g;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        last_g    = -1;
        do_reset();
        chk("reset_valid", rsp_valid, 0);
        chk("reset_id", rsp_id, 0);
        chk("reset_result", rsp_result, 0);
        chk("reset_flags", rsp_flags, 0);
        chk("reset_err", rsp_err, 0);

        rsp_ready = 1'b1;
        set_req(0, 1, 4'd0, 5, 7);
        do_cycle();
        req_valid = '0;
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 0);
        chk("single_result", rsp_result, 12);
        chk("single_flags", rsp_flags, 0);
        chk("single_err", rsp_err, 0);
        do_cycle();

        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1, 4'd0, 1, 2);
        set_req(1, 1, 4'd4, 3, 3);
        for (int n = 0; n < 4; n++) begin
            do_cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = n % 2;
`endif
            chk("contention_grant", last_g, exp_g);
            chk("contention_rsp", rsp_valid, 1);
        end
        req_valid = '0;
        do_cycle();

        set_req(0, 1, 4'd1, 9, 9);
        do_cycle();
        req_valid = '0;
        chk("flag_sub_flags", rsp_flags, 3'b001);
        chk("flag_sub_result", rsp_result, 0);
        set_req(0, 1, 4'd0, 9, 9);
        do_cycle();
        req_valid = '0;
        chk("flag_add_flags", rsp_flags, 3'b000);
        chk("flag_add_result", rsp_result, 18);
        chk("flag_add_known", $isunknown({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err}), 0);
        set_req(1, 1, 4'd5, 32'hFFFF_FFFF, 1);
        do_cycle();
        req_valid = '0;
        chk("flag_slt_flags", rsp_flags, 3'b010);

        set_req(0, 1, 4'd0, 1, 2);
        do_cycle();
        req_valid = '0;
        chk("bp_first_result", rsp_result, 3);
        rsp_ready = 1'b0;
        set_req(0, 1, 4'd2, 32'hF0, 32'h3C);
        set_req(1, 1, 4'd3, 1, 2);
        repeat (5) begin
            do_cycle();
            chk("bp_ready", req_ready, 0);
            chk("bp_result", rsp_result, 3);
            chk("bp_id", rsp_id, 0);
        end
        rsp_ready = 1'b1;
        do_cycle();
        chk("bp_resume_grant", last_g >= 0, 1);
        chk("bp_resume_valid", rsp_valid, 1);
        if (last_g >= 0) req_valid[last_g] = 1'b0;
        do_cycle();
        req_valid = '0;
        do_cycle();

        set_req(0, 1, 4'b1100, 1, 1);
        do_cycle();
        req_valid = '0;
        chk("illegal_grant", last_g, 0);
        chk("illegal_result", rsp_result, 0);
        chk("illegal_flags", rsp_flags, 0);
        chk("illegal_err", rsp_err, 1);
        do_cycle();

        rsp_ready = 1'b0;
        set_req(0, 1, 4'd0, 4, 4);
        do_cycle();
        req_valid[0] = 1'b0;
        set_req(1, 1, 4'd0, 2, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rsp_valid, 0);
        chk("async_rst_result", rsp_result, 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        set_req(0, 1, 4'd0, 6, 6);
        set_req(1, 1, 4'd0, 7, 7);
        do_cycle();
        chk("post_reset_grant", last_g, 0);
        req_valid = '0;
        rsp_ready = 1'b1;
        do_cycle();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    a = $urandom;
                    set_req(i, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), a,
                            ($urandom_range(0, 3) == 0) ? a : $urandom);
                end
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            do_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
